// File: rtl/tile_pixel_fetch_if.sv
// tile_pixel_fetch_if: timing, tile-map and ROM bus of the pixel fetch engine.
// i_*: from the timing generator, tile map and ROMs. o_*: from the fetch engine.
interface tile_pixel_fetch_if;
  logic        i_active;
  logic        i_frame_start;
  logic [1:0]  i_tile_kind;
  logic [11:0] i_ground_px;
  logic [11:0] i_platform_px;
  logic [11:0] i_coin_dark_px;
  logic [11:0] i_coin_mid_px;
  logic [11:0] i_coin_light_px;
  logic [4:0]  o_map_col;
  logic [4:0]  o_map_row;
  logic [9:0]  o_rom_addr;
  logic [11:0] o_pix_rgb;
  logic        o_pix_valid;
  modport master (
    output i_active, i_frame_start, i_tile_kind, i_ground_px, i_platform_px,
           i_coin_dark_px, i_coin_mid_px, i_coin_light_px,
    input  o_map_col, o_map_row, o_rom_addr, o_pix_rgb, o_pix_valid
  );
  modport slave (
    input  i_active, i_frame_start, i_tile_kind, i_ground_px, i_platform_px,
           i_coin_dark_px, i_coin_mid_px, i_coin_light_px,
    output o_map_col, o_map_row, o_rom_addr, o_pix_rgb, o_pix_valid
  );
endinterface

// File: rtl/tile_pixel_fetch.sv
// tile_pixel_fetch: per-pixel tile/coin ROM fetch with a 3-cycle RGB pipeline.
// clk: pixel clock. rst_n: asynchronous active-low reset.
// bus (slave): active/frame_start timing, tile_kind map response, ROM pixel data in;
//   map_col/map_row tile position, shared rom_addr, pix_rgb/pix_valid stream out.
module tile_pixel_fetch #(
  parameter logic [11:0] TRANSPARENT = 12'hF0F,
  parameter logic [11:0] BG_RGB = 12'h6AF,
  parameter int ANIM_FRAMES = 8
) (
  input logic clk,
  input logic rst_n,
  tile_pixel_fetch_if.slave bus
);
  localparam int FW = ANIM_FRAMES > 1 ? $clog2(ANIM_FRAMES) : 1;
  logic [4:0] r_fx, r_fy, r_col, r_row;
  logic r_act_d;
  logic [FW-1:0] r_frm;
  logic [1:0] r_phase, r_k1, r_k2, r_p1, r_p2;
  logic r_t1, r_t2, r_a1, r_a2;
  logic [9:0] r_rom_addr;
  logic [11:0] r_rgb;
  logic r_valid;
  logic w_eol, w_win, w_transp, w_frm_wrap;
  logic [9:0] w_gaddr, w_caddr, w_addr;
  logic [11:0] w_src, w_rgb;
  always_comb begin
    w_eol = r_act_d & ~bus.i_active;
    w_frm_wrap = r_frm == FW'(ANIM_FRAMES - 1);
    w_win = r_fx >= 5'd4 && r_fx <= 5'd19 && r_fy >= 5'd4 && r_fy <= 5'd19;
    w_transp = bus.i_tile_kind == 2'd0 || (bus.i_tile_kind == 2'd3 && !w_win);
    w_gaddr = ({5'd0, r_fy} << 4) + ({5'd0, r_fy} << 3) + {5'd0, r_fx};
    w_caddr = (({5'd0, r_fy} - 10'd4) << 4) + {5'd0, r_fx} - 10'd4;
    w_addr = w_transp ? 10'd0 : bus.i_tile_kind == 2'd3 ? w_caddr : w_gaddr;
    w_src = r_k2 == 2'd1 ? bus.i_ground_px :
            r_k2 == 2'd2 ? bus.i_platform_px :
            r_p2 == 2'd0 ? bus.i_coin_dark_px :
            r_p2 == 2'd2 ? bus.i_coin_light_px : bus.i_coin_mid_px;
    w_rgb = !r_a2 ? 12'd0 : (r_t2 || w_src == TRANSPARENT) ? BG_RGB : w_src;
  end
  // frame_start outranks end-of-line and pixel advance; the pixel in its cycle still uses old coordinates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fx <= '0;
      r_fy <= '0;
      r_col <= '0;
      r_row <= '0;
      r_act_d <= 1'b0;
      r_frm <= '0;
      r_phase <= '0;
    end else begin
      r_act_d <= bus.i_active;
      if (bus.i_frame_start) begin
        r_fx <= '0;
        r_fy <= '0;
        r_col <= '0;
        r_row <= '0;
      end else if (w_eol) begin
        r_fx <= '0;
        r_col <= '0;
        r_fy <= r_fy == 5'd23 ? 5'd0 : r_fy + 5'd1;
        r_row <= r_fy == 5'd23 ? r_row + 5'd1 : r_row;
      end else if (bus.i_active) begin
        r_fx <= r_fx == 5'd23 ? 5'd0 : r_fx + 5'd1;
        r_col <= r_fx == 5'd23 ? r_col + 5'd1 : r_col;
      end
      if (bus.i_frame_start) begin
        r_frm <= w_frm_wrap ? '0 : r_frm + FW'(1);
        r_phase <= w_frm_wrap ? r_phase + 2'd1 : r_phase;
      end
    end
  end
  // pixel attributes travel with the address so phase changes never hit in-flight pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      {r_k1, r_p1, r_t1, r_a1} <= '0;
      {r_k2, r_p2, r_t2, r_a2} <= '0;
      r_rgb <= '0;
      r_valid <= 1'b0;
    end else begin
      r_rom_addr <= w_addr;
      {r_k1, r_p1, r_t1, r_a1} <= {bus.i_tile_kind, r_phase, w_transp, bus.i_active};
      {r_k2, r_p2, r_t2, r_a2} <= {r_k1, r_p1, r_t1, r_a1};
      r_rgb <= w_rgb;
      r_valid <= r_a2;
    end
  end
  assign bus.o_map_col = r_col;
  assign bus.o_map_row = r_row;
  assign bus.o_rom_addr = r_rom_addr;
  assign bus.o_pix_rgb = r_rgb;
  assign bus.o_pix_valid = r_valid;
endmodule

// File: tb/tb_tile_pixel_fetch.sv
// tb_tile_pixel_fetch: randomized self-checking bench against a coordinate-level reference model.
module tb_tile_pixel_fetch;
  localparam logic [11:0] TR = 12'hF0F;
  localparam logic [11:0] BG = 12'h6AF;
  localparam int AF = 2;
  typedef struct {
    logic act;
    logic [9:0] addr;
    logic [11:0] rgb;
  } pix_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] map_tbl [32][32];
  pix_t hist [3];
  int x, y, nframes, n_cmp, n_bad, salt, e_col, e_row;
  bit prev_act, ovr_en;
  logic [11:0] ovr_val;
  logic [4:0] s_col, s_row;
  always #5 clk = ~clk;
  tile_pixel_fetch_if bus();
  tile_pixel_fetch #(.TRANSPARENT(TR), .BG_RGB(BG), .ANIM_FRAMES(AF)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  assign bus.i_tile_kind = map_tbl[bus.o_map_row][bus.o_map_col];
  function automatic logic [11:0] rom(int sel, logic [9:0] a);
    return ovr_en ? ovr_val : 12'(int'(a) * 37 + sel * 1111 + salt);
  endfunction
  function automatic pix_t model(bit act);
    int fx = x % 24;
    int fy = y % 24;
    int ph = (nframes / AF) % 4;
    int sel;
    logic [1:0] k;
    bit tr;
    logic [11:0] d;
    pix_t p;
    k = map_tbl[(y / 24) % 32][(x / 24) % 32];
    tr = k == 0 || (k == 3 && !(fx >= 4 && fx <= 19 && fy >= 4 && fy <= 19));
    p.act = act;
    p.addr = tr ? 10'd0 : k == 3 ? 10'((fy - 4) * 16 + fx - 4) : 10'(fy * 24 + fx);
    sel = k == 1 ? 0 : k == 2 ? 1 : ph == 0 ? 2 : ph == 2 ? 4 : 3;
    d = rom(sel, p.addr);
    p.rgb = !act ? 12'd0 : (tr || d == TR) ? BG : d;
    return p;
  endfunction
  task automatic fill_map(int mode);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        map_tbl[r][c] = mode < 4 ? 2'(mode) : 2'($urandom_range(0, 3));
  endtask
  task automatic clear_model();
    x = 0; y = 0; nframes = 0; prev_act = 0;
    foreach (hist[i]) hist[i] = '{act: 1'b0, addr: 10'd0, rgb: 12'd0};
  endtask
  task automatic do_reset();
    bus.i_active = 0; bus.i_frame_start = 0;
    rst_n = 0;
    clear_model();
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  // one pixel clock: drive timing, record the model's expectation, then model a 1-cycle ROM
  task automatic step(input bit act, input bit fs);
    logic [9:0] a;
    a = bus.o_rom_addr;
    bus.i_active = act; bus.i_frame_start = fs;
    e_col = (x / 24) % 32; e_row = (y / 24) % 32;
    s_col = bus.o_map_col; s_row = bus.o_map_row;
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = model(act);
    @(posedge clk); #1;
    bus.i_ground_px = rom(0, a);
    bus.i_platform_px = rom(1, a);
    bus.i_coin_dark_px = rom(2, a);
    bus.i_coin_mid_px = rom(3, a);
    bus.i_coin_light_px = rom(4, a);
    if (fs) begin x = 0; y = 0; nframes++; end
    else if (act) x++;
    else if (prev_act) begin x = 0; y++; end
    prev_act = act;
  endtask
  task automatic test_reset();
    rst_n = 0;
    bus.i_active = 1; bus.i_frame_start = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.o_map_col, bus.o_map_row, bus.o_rom_addr, bus.o_pix_rgb, bus.o_pix_valid} !== 33'd0) begin
      n_bad++;
      $display("FAIL reset outputs got col=%h row=%h addr=%h rgb=%h valid=%b want all 0",
               bus.o_map_col, bus.o_map_row, bus.o_rom_addr, bus.o_pix_rgb, bus.o_pix_valid);
    end
    do_reset();
  endtask
  task automatic test_latency();
    bit ev;
    ovr_en = 1; ovr_val = 12'h123; fill_map(1);
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(i < 10, 0);
      ev = i >= 2 && i <= 11;
      n_cmp++;
      if (bus.o_pix_valid !== ev || bus.o_pix_rgb !== (ev ? 12'h123 : 12'h000)) begin
        n_bad++;
        $display("FAIL latency cycle %0d got valid=%b rgb=%h want valid=%b rgb=%h",
                 i + 1, bus.o_pix_valid, bus.o_pix_rgb, ev, ev ? 12'h123 : 12'h000);
      end
    end
  endtask
  task automatic test_addressing();
    ovr_en = 0; salt = $urandom_range(0, 4095); fill_map(1);
    do_reset();
    for (int l = 0; l < 26; l++)
      for (int i = 0; i < 28; i++) begin
        step(i < 26, 0);
        if (l == 0 && i < 26) begin
          n_cmp++;
          if (bus.o_rom_addr !== 10'(i % 24) || s_col !== 5'(i / 24)) begin
            n_bad++;
            $display("FAIL line0 px %0d got addr=%0d col=%0d want addr=%0d col=%0d",
                     i, bus.o_rom_addr, s_col, i % 24, i / 24);
          end
        end
        if (hist[0].act) begin
          n_cmp++;
          if ({s_row, s_col, bus.o_rom_addr} !== {5'(e_row), 5'(e_col), hist[0].addr}) begin
            n_bad++;
            $display("FAIL addressing row/col/addr got %0d/%0d/%0d want %0d/%0d/%0d",
                     s_row, s_col, bus.o_rom_addr, e_row, e_col, hist[0].addr);
          end
        end
        n_cmp++;
        if ({bus.o_pix_valid, bus.o_pix_rgb} !== {hist[2].act, hist[2].rgb}) begin
          n_bad++;
          $display("FAIL addressing pixel got %b/%h want %b/%h",
                   bus.o_pix_valid, bus.o_pix_rgb, hist[2].act, hist[2].rgb);
        end
      end
  endtask
  task automatic test_coin_window();
    ovr_en = 1; ovr_val = 12'h555; fill_map(3);
    do_reset();
    for (int l = 0; l < 21; l++)
      for (int i = 0; i < 26; i++) begin
        step(i < 24, 0);
        if ((l == 4 && i == 4) || (l == 19 && i == 19)) begin
          n_cmp++;
          if (bus.o_rom_addr !== (l == 4 ? 10'd0 : 10'd255)) begin
            n_bad++;
            $display("FAIL coin addr fx=fy=%0d got %0d want %0d", l, bus.o_rom_addr, l == 4 ? 0 : 255);
          end
        end
        if (l == 10 && (i == 5 || i == 6)) begin
          n_cmp++;
          if (bus.o_pix_rgb !== (i == 5 ? BG : 12'h555)) begin
            n_bad++;
            $display("FAIL coin edge fx=%0d got %h want %h", i - 2, bus.o_pix_rgb, i == 5 ? BG : 12'h555);
          end
        end
        n_cmp++;
        if ({bus.o_pix_valid, bus.o_pix_rgb} !== {hist[2].act, hist[2].rgb}) begin
          n_bad++;
          $display("FAIL coin pixel got %b/%h want %b/%h",
                   bus.o_pix_valid, bus.o_pix_rgb, hist[2].act, hist[2].rgb);
        end
      end
  endtask
  task automatic test_transparency();
    for (int m = 0; m < 2; m++) begin
      ovr_en = m == 0; ovr_val = TR; salt = $urandom_range(0, 4095); fill_map(m == 0 ? 1 : 0);
      do_reset();
      for (int i = 0; i < 12; i++) begin
        step(i < 9, 0);
        n_cmp++;
        if (bus.o_pix_rgb !== (i >= 2 && i <= 10 ? BG : 12'h000)) begin
          n_bad++;
          $display("FAIL transparency mode %0d cycle %0d got %h want %h",
                   m, i, bus.o_pix_rgb, i >= 2 && i <= 10 ? BG : 12'h000);
        end
      end
    end
  endtask
  task automatic test_animation();
    ovr_en = 0; salt = $urandom_range(0, 4095); fill_map(3);
    do_reset();
    for (int f = 0; f < 10; f++) begin
      step(0, 1);
      for (int l = 0; l < 5; l++)
        for (int i = 0; i < 26; i++) begin
          step(i < 24, 0);
          n_cmp++;
          if ({bus.o_pix_valid, bus.o_pix_rgb} !== {hist[2].act, hist[2].rgb}) begin
            n_bad++;
            $display("FAIL animation frame %0d pixel got %b/%h want %b/%h",
                     f, bus.o_pix_valid, bus.o_pix_rgb, hist[2].act, hist[2].rgb);
          end
        end
    end
  endtask
  task automatic test_priority();
    ovr_en = 0; salt = $urandom_range(0, 4095); fill_map(1);
    do_reset();
    for (int i = 0; i < 79; i++) step(1, 0);
    step(1, 1);
    n_cmp++;
    if (s_col !== 5'd3 || bus.o_rom_addr !== 10'd7) begin
      n_bad++;
      $display("FAIL priority fs pixel got col=%0d addr=%0d want col=3 addr=7", s_col, bus.o_rom_addr);
    end
    step(1, 0);
    n_cmp++;
    if (s_col !== 5'd0 || bus.o_rom_addr !== 10'd0) begin
      n_bad++;
      $display("FAIL priority next pixel got col=%0d addr=%0d want col=0 addr=0", s_col, bus.o_rom_addr);
    end
  endtask
  task automatic test_reset_midline();
    ovr_en = 0; fill_map(1);
    do_reset();
    for (int i = 0; i < 30; i++) step(1, 0);
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({bus.o_map_col, bus.o_map_row, bus.o_rom_addr, bus.o_pix_rgb, bus.o_pix_valid} !== 33'd0) begin
      n_bad++;
      $display("FAIL async reset got col=%h row=%h addr=%h rgb=%h valid=%b want all 0",
               bus.o_map_col, bus.o_map_row, bus.o_rom_addr, bus.o_pix_rgb, bus.o_pix_valid);
    end
    clear_model();
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      step(1, 0);
      n_cmp++;
      if ({s_col, bus.o_rom_addr} !== {5'd0, 10'(i)} || {bus.o_pix_valid, bus.o_pix_rgb} !== {hist[2].act, hist[2].rgb}) begin
        n_bad++;
        $display("FAIL after reset px %0d got col=%0d addr=%0d rgb=%b/%h want col=0 addr=%0d rgb=%b/%h",
                 i, s_col, bus.o_rom_addr, bus.o_pix_valid, bus.o_pix_rgb, i, hist[2].act, hist[2].rgb);
      end
    end
  endtask
  task automatic test_random();
    ovr_en = 0; salt = $urandom_range(0, 4095); fill_map(4);
    do_reset();
    for (int l = 0; l < 40; l++) begin
      int n = $urandom_range(0, 1) ? $urandom_range(1, 60) : $urandom_range(400, 700);
      int g = $urandom_range(1, 4);
      int fpos = $urandom_range(0, 15) == 0 ? $urandom_range(0, n + g - 1) : -1;
      for (int i = 0; i < n + g; i++) begin
        step(i < n, i == fpos);
        if (hist[0].act) begin
          n_cmp++;
          if ({s_row, s_col, bus.o_rom_addr} !== {5'(e_row), 5'(e_col), hist[0].addr}) begin
            n_bad++;
            $display("FAIL random fetch row/col/addr got %0d/%0d/%0d want %0d/%0d/%0d",
                     s_row, s_col, bus.o_rom_addr, e_row, e_col, hist[0].addr);
          end
        end
        n_cmp++;
        if ({bus.o_pix_valid, bus.o_pix_rgb} !== {hist[2].act, hist[2].rgb}) begin
          n_bad++;
          $display("FAIL random pixel got %b/%h want %b/%h",
                   bus.o_pix_valid, bus.o_pix_rgb, hist[2].act, hist[2].rgb);
        end
      end
    end
  endtask
  initial begin
    n_cmp = 0; n_bad = 0; salt = 0; ovr_en = 0; ovr_val = 12'h000;
    bus.i_active = 0; bus.i_frame_start = 0;
    bus.i_ground_px = 0; bus.i_platform_px = 0;
    bus.i_coin_dark_px = 0; bus.i_coin_mid_px = 0; bus.i_coin_light_px = 0;
    fill_map(1);
    clear_model();
    test_reset();
    test_latency();
    test_addressing();
    test_coin_window();
    test_transparency();
    test_animation();
    test_priority();
    test_reset_midline();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tile_pixel_fetch.md
# tile_pixel_fetch

Per-pixel fetch engine between the VGA timing generator and the 24x24 tile / 16x16 coin sprite ROMs. Tracks the on-screen tile grid position with incremental counters and queries an external tile map. Drives the shared ROM address bus (1-cycle registered-read ROMs) and selects the returned pixel, applying transparency and coin animation. Emits a pipelined 12-bit RGB stream with a valid flag.

## Interface
- TRANSPARENT, 12'hF0F: ROM colour key treated as see-through
- BG_RGB, 12'h6AF: background colour for empty/transparent pixels
- ANIM_FRAMES, 8: video frames per coin animation phase (>=1)

- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- active  in  1  current cycle is a visible pixel
- frame_start  in  1  one-cycle pulse at start of each frame, normally in blanking
- tile_kind  in  2  map response for map_col/map_row, same cycle: 0 empty, 1 ground, 2 platform, 3 coin
- ground_px, platform_px  in  12 each  ROM data, 1 cycle after rom_addr
- coin_dark_px, coin_mid_px, coin_light_px  in  12 each  coin ROM data, 1 cycle after rom_addr
- map_col  out  5  tile column of the current pixel, direct from counter register
- map_row  out  5  tile row of the current pixel, direct from counter register
- rom_addr  out  10  registered address shared by all ROMs
- pix_rgb  out  12  registered output colour
- pix_valid  out  1  pix_rgb corresponds to a visible pixel

## Operation
- Counters: fx (0..23), col (0..31), fy (0..23), row (0..31).
- On each active cycle: fx++. When fx is 23, fx<=0 and col++.
- On each active 1->0 edge (end of line), detected from a registered copy of active: fx<=0, col<=0, fy++. When fy is 23, fy<=0 and row++.
- col and row wrap mod 32. This is never reached at 640x480 (max col 26, max row 19).
- frame_start: clears fx, col, fy, row. It has priority over increment and end-of-line.
- If frame_start coincides with active, the current pixel is still fetched using the pre-clear coordinates.
- Address generation for kind 1/2: fy*24+fx, range 0..575.
- Address generation for kind 3: window is 4<=fx<=19 and 4<=fy<=19; address is (fy-4)*16+(fx-4), range 0..255.
- Kind 3 outside the window, and kind 0: rom_addr<=0 and the pixel is marked transparent.
- Multiply by 24 is implemented as (fy<<4)+(fy<<3); no divider.
- Animation: frame counter 0..ANIM_FRAMES-1 advances on frame_start. On wrap, phase advances 0->1->2->3->0.
- Phase-to-ROM mapping: 0 dark, 1 mid, 2 light, 3 mid.
- Kind, transparent flag, phase and active are carried down the pipeline alongside each pixel, so a mid-pipeline phase change never affects in-flight pixels.
- Output select:
  - pix_rgb = BG_RGB if the pixel is transparent or the selected ROM data equals TRANSPARENT.
  - Otherwise pix_rgb = the ROM data selected by the pipelined kind/phase.
  - pix_rgb = 0 when the pipelined active is 0.

## Timing
- Cycle T: active=1, counters show pixel p, map_col/map_row are valid, tile_kind is sampled at the T edge.
- T+1: rom_addr holds p's address.
- T+2: ROM data for p is present on the *_px inputs.
- T+3: pix_rgb and pix_valid for p are valid. Total latency is 3 cycles, fully pipelined at 1 pixel/clk, no stalls.
- pix_valid is active delayed exactly 3 cycles.
- Reset values: all counters 0, phase 0, frame counter 0, map_col 0, map_row 0, rom_addr 0, pix_rgb 0, pix_valid 0, all pipeline flags 0.
- Reset mid-line asynchronously clears everything. The first active pixel after release is fetched as tile (0,0), fx=0, fy=0.

## Test plan
- Latency: all-ground map, active rises at cycle 0, ground_px=12'h123 -> pix_valid=1 and pix_rgb=12'h123 first at cycle 3; pix_valid falls 3 cycles after active falls.
- Addressing: all-ground map, line 0 pixels 0..25 -> rom_addr 0..23, then 0,1; map_col 0 then 1 at pixel 24. After end of line, line 1 pixel 0 -> rom_addr 24. Line 24 -> map_row 1, rom_addr 0.
- Coin window: kind 3 at fx=4,fy=4 -> rom_addr 0; at fx=19,fy=19 -> 255; at fx=3 -> pix_rgb=BG_RGB regardless of ROM data.
- Transparency: ground ROM returns 12'hF0F -> pix_rgb 12'h6AF; kind 0 -> 12'h6AF.
- Animation: ANIM_FRAMES=2, coin tile, 10 frame_start pulses -> ROM source per frame pair is dark, mid, light, mid, dark.
- Reset/priority: rst_n low for 1 cycle mid-line -> all outputs 0 immediately. frame_start with active=1 at fx=7,col=3 -> that pixel addresses fx=7 and the next pixel addresses rom_addr 0, map_col 0.
